// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer controller.
package btb_pkg;

  typedef logic [1:0] btb_ctr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } btb_state_t;

  localparam btb_ctr_t CTR_INIT = 2'b10;
  localparam btb_ctr_t CTR_MAX  = 2'b11;

  // Saturating 2-bit direction counter step.
  function automatic btb_ctr_t ctr_next(btb_ctr_t ctr, logic taken);
    if (taken) return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_if.sv
// Fetch lookup, EX update and flush signals of the BTB controller.
interface btb_if;
  logic        lkup_valid;
  logic [31:0] lkup_pc;
  logic        lkup_hit;
  logic        lkup_taken;
  logic [31:0] lkup_target;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        flush_req;
  logic        flush_busy;

  modport master (
    output lkup_valid, lkup_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
    input  lkup_hit, lkup_taken, lkup_target, upd_ready, flush_busy
  );

  modport slave (
    input  lkup_valid, lkup_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
    output lkup_hit, lkup_taken, lkup_target, upd_ready, flush_busy
  );
endinterface

// File: rtl/btb_data_array.sv
// Per-way target store indexed by PC bits; asynchronous read, unreset contents.
module btb_data_array #(
  parameter int s_index  = 4,
  parameter int s_offset = 2
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o
);
  logic [31:0] mem_q [2**s_index];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i[s_index+s_offset-1:s_offset]] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i[s_index+s_offset-1:s_offset]];

  wire unused_addr_bits = ^{waddr_i[31:s_index+s_offset], waddr_i[s_offset-1:0],
                            raddr_i[31:s_index+s_offset], raddr_i[s_offset-1:0]};
endmodule

// File: rtl/btb_way_meta.sv
// One BTB way's tag, valid and counter arrays with clear-by-index and lookup bypass.
module btb_way_meta
  import btb_pkg::*;
#(
  parameter int s_index = 4,
  parameter int s_tag   = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic [s_index-1:0] clr_idx_i,
  input  logic               wr_i,
  input  logic [s_index-1:0] wr_idx_i,
  input  logic [s_tag-1:0]   wr_tag_i,
  input  btb_ctr_t           wr_ctr_i,
  input  logic [s_index-1:0] lk_idx_i,
  output logic               lk_valid_o,
  output logic [s_tag-1:0]   lk_tag_o,
  output btb_ctr_t           lk_ctr_o,
  input  logic [s_index-1:0] up_idx_i,
  output logic               up_valid_o,
  output logic [s_tag-1:0]   up_tag_o,
  output btb_ctr_t           up_ctr_o
);
  localparam int NumSets = 2**s_index;

  logic [NumSets-1:0] valid_q;
  btb_ctr_t           ctr_q [NumSets];
  logic [s_tag-1:0]   tag_q [NumSets];

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NumSets; i++) ctr_q[i] <= '0;
    end else if (clr_i) begin
      valid_q[clr_idx_i] <= 1'b0;
      ctr_q[clr_idx_i]   <= '0;
    end else if (wr_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      ctr_q[wr_idx_i]   <= wr_ctr_i;
    end
  end

  // NOTE: tags are never reset; a cleared valid bit makes any stale tag harmless.
  always_ff @(posedge clk) begin
    if (wr_i) tag_q[wr_idx_i] <= wr_tag_i;
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    lk_valid_o = valid_q[lk_idx_i];
    lk_tag_o   = tag_q[lk_idx_i];
    lk_ctr_o   = ctr_q[lk_idx_i];
    if (wr_i && (wr_idx_i == lk_idx_i)) begin
      lk_valid_o = 1'b1;
      lk_tag_o   = wr_tag_i;
      lk_ctr_o   = wr_ctr_i;
    end
  end

  assign up_valid_o = valid_q[up_idx_i];
  assign up_tag_o   = tag_q[up_idx_i];
  assign up_ctr_o   = ctr_q[up_idx_i];
endmodule

// File: rtl/btb_controller.sv
// 2-way BTB controller: lookup, update/allocation, LRU and flush walk.
// Define BTB_STATS_EN to add saturating lookup/hit/mispredict counters.
module btb_controller
  import btb_pkg::*;
#(
  parameter int s_index = 4,
  parameter int s_tag   = 26
) (
  input  logic  clk,
  input  logic  rst_n,
  btb_if.slave  bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispredicts
`endif
);
  localparam int NumSets = 2**s_index;
  localparam logic [s_index-1:0] FidxLast = '1;

  btb_state_t          state_q, state_d;
  logic [s_index-1:0]  fidx_q, fidx_d;
  logic [NumSets-1:0]  lru_q;
  logic                flushing;

  logic [s_index-1:0]  lk_idx, up_idx;
  logic [s_tag-1:0]    lk_tag, up_tag;
  logic [1:0]          lk_valid, up_valid, lk_match, up_match, meta_wr, data_wr;
  logic [s_tag-1:0]    lk_tagr [2];
  logic [s_tag-1:0]    up_tagr [2];
  btb_ctr_t            lk_ctr [2];
  btb_ctr_t            up_ctr [2];
  logic [31:0]         rd_target [2];
  logic                upd_fire, up_hit, wr_way, lru_wr, lk_way, lk_hit;
  logic [31:0]         lk_target;
  btb_ctr_t            wr_ctr;

  assign lk_idx   = bus.lkup_pc[s_index+1:2];
  assign lk_tag   = bus.lkup_pc[31:s_index+2];
  assign up_idx   = bus.upd_pc[s_index+1:2];
  assign up_tag   = bus.upd_pc[31:s_index+2];
  assign upd_fire = bus.upd_valid & bus.upd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fidx_d  = '0;
    case (state_q)
      IDLE:    if (bus.flush_req) state_d = FLUSH;
      FLUSH: begin
        fidx_d = fidx_q + s_index'(1);
        if (fidx_q == FidxLast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flushing       = (state_q == FLUSH);
    bus.flush_busy = flushing;
    bus.upd_ready  = (state_q == IDLE) & ~bus.flush_req;
  end

  // Update side: hit way, else first invalid way, else the LRU way.
  always_comb begin
    up_match[0] = up_valid[0] & (up_tagr[0] == up_tag);
    up_match[1] = up_valid[1] & (up_tagr[1] == up_tag);
    up_hit      = |up_match;
    if (up_hit)            wr_way = up_match[1];
    else if (!up_valid[0]) wr_way = 1'b0;
    else if (!up_valid[1]) wr_way = 1'b1;
    else                   wr_way = lru_q[up_idx];
    wr_ctr  = up_hit ? ctr_next(up_ctr[wr_way], bus.upd_taken) : CTR_INIT;
    lru_wr  = upd_fire & (up_hit | bus.upd_taken);
    meta_wr = {lru_wr & wr_way, lru_wr & ~wr_way};
    data_wr = meta_wr & {2{bus.upd_taken}};
  end

  for (genvar w = 0; w < 2; w++) begin : g_way
    btb_way_meta #(.s_index(s_index), .s_tag(s_tag)) u_meta (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (flushing),
      .clr_idx_i  (fidx_q),
      .wr_i       (meta_wr[w]),
      .wr_idx_i   (up_idx),
      .wr_tag_i   (up_tag),
      .wr_ctr_i   (wr_ctr),
      .lk_idx_i   (lk_idx),
      .lk_valid_o (lk_valid[w]),
      .lk_tag_o   (lk_tagr[w]),
      .lk_ctr_o   (lk_ctr[w]),
      .up_idx_i   (up_idx),
      .up_valid_o (up_valid[w]),
      .up_tag_o   (up_tagr[w]),
      .up_ctr_o   (up_ctr[w])
    );

    btb_data_array #(.s_index(s_index), .s_offset(2)) u_data (
      .clk     (clk),
      .we_i    (data_wr[w]),
      .waddr_i (bus.upd_pc),
      .wdata_i (bus.upd_target),
      .raddr_i (bus.lkup_pc),
      .rdata_o (rd_target[w])
    );
  end

  // Lookup side; the target bypass mirrors the meta bypass for a same-cycle write.
  always_comb begin
    lk_match[0] = lk_valid[0] & (lk_tagr[0] == lk_tag);
    lk_match[1] = lk_valid[1] & (lk_tagr[1] == lk_tag);
    lk_way      = lk_match[1];
    lk_target   = rd_target[lk_way];
    if (data_wr[lk_way] && (up_idx == lk_idx)) lk_target = bus.upd_target;
    lk_hit          = ~flushing & (|lk_match);
    bus.lkup_hit    = lk_hit;
    bus.lkup_taken  = lk_hit & lk_ctr[lk_way][1];
    bus.lkup_target = lk_hit ? lk_target : '0;
  end

  // The update write comes last so it wins when both touch the same set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lru_q <= '0;
    end else if (flushing) begin
      lru_q[fidx_q] <= 1'b0;
    end else begin
      if (bus.lkup_valid && lk_hit) lru_q[lk_idx] <= ~lk_way;
      if (lru_wr)                   lru_q[up_idx] <= ~wr_way;
    end
  end

`ifdef BTB_STATS_EN
  logic mispredict;
  assign mispredict = upd_fire & ((up_hit & up_ctr[wr_way][1]) != bus.upd_taken);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (bus.lkup_valid && !flushing && stat_lookups != '1) stat_lookups <= stat_lookups + 32'd1;
      if (bus.lkup_valid && lk_hit && stat_hits != '1)        stat_hits    <= stat_hits + 32'd1;
      if (mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_btb_controller.sv
// Directed bench for btb_controller: lookup, update, replacement, flush walk, reset mid-flush.
module tb_btb_controller;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cycles;

  btb_if bus ();

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

  btb_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.lkup_valid = 1'b0;
    bus.lkup_pc    = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_target = '0;
    bus.upd_taken  = 1'b0;
    bus.flush_req  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = taken;
    tick();
    bus.upd_valid  = 1'b0;
  endtask

  task automatic lookup_chk(input string tag, input logic [31:0] pc, input logic hit,
                            input logic taken, input logic [31:0] tgt);
    bus.lkup_valid = 1'b1;
    bus.lkup_pc    = pc;
    #1;
    check({tag, "_hit"},    32'(bus.lkup_hit),   32'(hit));
    check({tag, "_taken"},  32'(bus.lkup_taken), 32'(taken));
    check({tag, "_target"}, bus.lkup_target,     tgt);
    bus.lkup_valid = 1'b0;
    tick();
  endtask

  initial begin
    do_reset();

    // Reset state
    check("rst_ready", 32'(bus.upd_ready),  32'd1);
    check("rst_busy",  32'(bus.flush_busy), 32'd0);
    lookup_chk("rst_lk", 32'h0000_1000, 1'b0, 1'b0, 32'h0);

    // Allocate, then train the counter down
    upd(32'h0000_1000, 32'h0000_2000, 1'b1);
    lookup_chk("alloc", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000);
    upd(32'h0000_1000, 32'h0000_dead, 1'b0);
    lookup_chk("nt1", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000);
    upd(32'h0000_1000, 32'h0000_beef, 1'b0);
    lookup_chk("nt2", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000);

    // Same-cycle update and lookup bypass
    do_reset();
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h0000_0040;
    bus.upd_target = 32'h0000_0080;
    bus.upd_taken  = 1'b1;
    bus.lkup_valid = 1'b1;
    bus.lkup_pc    = 32'h0000_0040;
    #1;
    check("byp_hit",    32'(bus.lkup_hit),   32'd1);
    check("byp_taken",  32'(bus.lkup_taken), 32'd1);
    check("byp_target", bus.lkup_target,     32'h0000_0080);
    tick();
    clear_inputs();

    // LRU replacement in set 0
    upd(32'h0000_0440, 32'h0000_0500, 1'b1);
    bus.lkup_valid = 1'b1;
    bus.lkup_pc    = 32'h0000_0040;
    tick();
    bus.lkup_valid = 1'b0;
    upd(32'h0000_0840, 32'h0000_0900, 1'b1);
    lookup_chk("evict_440", 32'h0000_0440, 1'b0, 1'b0, 32'h0);
    lookup_chk("keep_040",  32'h0000_0040, 1'b1, 1'b1, 32'h0000_0080);
    lookup_chk("new_840",   32'h0000_0840, 1'b1, 1'b1, 32'h0000_0900);

    // Flush walk with an update held across it
    upd(32'h0000_0104, 32'h0000_1104, 1'b1);
    upd(32'h0000_0208, 32'h0000_1208, 1'b1);
    upd(32'h0000_003c, 32'h0000_103c, 1'b1);
    bus.flush_req  = 1'b1;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h0000_0114;
    bus.upd_target = 32'h0000_0777;
    bus.upd_taken  = 1'b1;
    #1;
    check("flreq_ready", 32'(bus.upd_ready), 32'd0);
    tick();
    bus.flush_req = 1'b0;
    busy_cycles = 0;
    while (bus.flush_busy && busy_cycles < 40) begin
      bus.lkup_valid = 1'b1;
      bus.lkup_pc    = 32'h0000_0104;
      #1;
      check("walk_ready", 32'(bus.upd_ready), 32'd0);
      check("walk_hit",   32'(bus.lkup_hit),  32'd0);
      busy_cycles++;
      tick();
    end
    bus.lkup_valid = 1'b0;
    check("walk_len",     32'(busy_cycles),  32'd16);
    check("post_ready",   32'(bus.upd_ready), 32'd1);
    tick();
    bus.upd_valid = 1'b0;
    lookup_chk("fl_104", 32'h0000_0104, 1'b0, 1'b0, 32'h0);
    lookup_chk("fl_208", 32'h0000_0208, 1'b0, 1'b0, 32'h0);
    lookup_chk("fl_03c", 32'h0000_003c, 1'b0, 1'b0, 32'h0);
    lookup_chk("fl_040", 32'h0000_0040, 1'b0, 1'b0, 32'h0);
    lookup_chk("held_114", 32'h0000_0114, 1'b1, 1'b1, 32'h0000_0777);

    // Reset in the middle of a flush walk
    upd(32'h0000_0104, 32'h0000_1104, 1'b1);
    upd(32'h0000_003c, 32'h0000_103c, 1'b1);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    repeat (5) tick();
    check("mid_busy", 32'(bus.flush_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstfl_busy",  32'(bus.flush_busy), 32'd0);
    check("rstfl_ready", 32'(bus.upd_ready),  32'd1);
`ifdef BTB_STATS_EN
    check("stat_lookups", stat_lookups,     32'd0);
    check("stat_hits",    stat_hits,        32'd0);
    check("stat_mispred", stat_mispredicts, 32'd0);
`endif
    lookup_chk("rstfl_104", 32'h0000_0104, 1'b0, 1'b0, 32'h0);
    lookup_chk("rstfl_114", 32'h0000_0114, 1'b0, 1'b0, 32'h0);
    lookup_chk("rstfl_03c", 32'h0000_003c, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/btb_controller.md
Name: btb_controller

Overview:
Sequencing and replacement controller for the branch target buffer (BTB), a 2-way set-associative store of predicted branch targets.
- Serves a same-cycle lookup port for the fetch stage.
- Accepts branch-resolution updates from EX via a valid/ready handshake.
- Owns the tags, valid bits, per-set LRU bits and 2-bit direction counters.
- Runs a multi-cycle flush walk that invalidates every set.
- Target storage is two instances of the team's btb_data_array, one per way.

Parameters:
s_index, 4, set index width; num_sets = 2**s_index
s_tag, 26, tag width; must equal 30 - s_index

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
lkup_valid  in  1  fetch lookup strobe
lkup_pc  in  32  fetch PC
lkup_hit  out  1  valid tag match in either way
lkup_taken  out  1  hit and direction counter bit 1 set
lkup_target  out  32  predicted target; 0 when no hit
upd_valid  in  1  resolved branch present
upd_ready  out  1  controller can accept update this cycle
upd_pc  in  32  PC of resolved branch
upd_target  in  32  resolved target
upd_taken  in  1  resolved direction
flush_req  in  1  request full invalidate (pulse or level)
flush_busy  out  1  flush walk in progress

Behaviour:
Address split and timing:
- index = pc[s_index+1:2]; tag = pc[31:s_index+2]; pc[1:0] ignored.
- Reset (rst_n low at posedge clk): all valid bits, LRU bits and counters go to 0; state = IDLE. Target arrays are not reset; valid bits gate them.
- After reset: lkup_hit=0, lkup_taken=0, lkup_target=0, flush_busy=0, upd_ready=1.

Lookup (combinational, zero latency):
- Lookup outputs are forced to 0 while state=FLUSH.
- Same-cycle accepted update to the same index: lookup sees the post-update tag, valid, counter and target (write-through bypass).
- At posedge, lkup_valid & lkup_hit sets LRU[index] to the non-hit way, unless an accepted update to the same index that cycle also writes LRU; the update wins.

Update (single cycle, commits at posedge when upd_valid & upd_ready):
- upd_ready = (state==IDLE) & ~flush_req.
- Hit, way w:
  - counter saturating +1 if taken (max 3), -1 if not taken (min 0).
  - target written only if taken.
  - LRU = ~w.
- Miss and taken: allocate a victim way.
  - Victim = first invalid way (way0 preferred), else LRU way.
  - Write tag, target, valid=1, counter=2'b10; LRU = ~victim.
- Miss and not taken: no state change.
- Both ways matching the same tag cannot occur: allocation happens only on a miss.

FSM: IDLE, FLUSH.
- IDLE -> FLUSH when flush_req=1. flush_req takes priority over a same-cycle upd_valid, which is not accepted.
- In FLUSH, counter fidx runs 0..num_sets-1. Each cycle it clears valid, counters and LRU of set fidx in both ways.
- FLUSH -> IDLE after fidx=num_sets-1 is cleared, so the walk takes exactly num_sets cycles.
- flush_busy = (state==FLUSH).
- flush_req during FLUSH is ignored; the walk does not restart.
- Reset mid-flush: immediate IDLE with all state cleared.

Optional Feature:
BTB_STATS_EN.
- When defined, adds outputs stat_lookups, stat_hits and stat_mispredicts, each 32 bits.
  - stat_lookups counts lkup_valid cycles outside FLUSH.
  - stat_hits counts those cycles with lkup_hit=1.
  - stat_mispredicts counts accepted updates where the predicted direction differs from upd_taken. Predicted direction is the hit entry's counter bit 1, or not-taken on a miss.
  - All three saturate at 32'hFFFF_FFFF and are cleared only by rst_n.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package btb_pkg holds:
  - typedef btb_ctr_t, a 2-bit counter;
  - enum btb_state_t {IDLE, FLUSH};
  - constants CTR_INIT=2'b10 and CTR_MAX=2'b11;
  - function ctr_next(ctr, taken).
- Natural sub-module btb_way_meta: per-way tag, valid and counter arrays with synchronous clear-by-index and same-cycle bypass. Instantiate it twice.
- Target storage reuses btb_data_array with s_offset=2, instantiated twice.

Test Plan:
1. Reset, then lookup 0x0000_1000 -> hit=0, taken=0, target=0; upd_ready=1.
2. Update pc=0x0000_1000, target=0x0000_2000, taken=1, then lookup next cycle -> hit=1, taken=1, target=0x0000_2000. Two not-taken updates -> taken=0, hit=1.
3. Same-cycle update and lookup of pc 0x40 with target 0x80 -> lookup already returns hit=1, target=0x80.
4. Allocate 0x0000_0040, then 0x0000_0440 (same index, different tag). Look up 0x40 so LRU points at the way holding 0x440. Allocate 0x0000_0840 -> 0x440 evicted; 0x40 and 0x840 both hit.
5. Fill several sets, assert flush_req one cycle:
   - flush_busy=1 for exactly 16 cycles and upd_ready=0 throughout;
   - lookups return hit=0 during the walk and after it;
   - an upd_valid held across the walk is accepted on the first IDLE cycle.
6. Assert rst_n=0 at flush cycle 5 -> next cycle flush_busy=0, all lookups miss. With BTB_STATS_EN, all stat counters read 0.
